// File: rtl/cdb_arbiter_pkg.sv
// Shared core definitions for the completion-bus arbiter: ROB sizing, CDB port count
// and the per-port completion payload.
package cdb_arbiter_pkg;

   localparam int unsigned NUM_ROB_ENTS = 32;
   localparam int unsigned ROB_IDX_W    = $clog2(NUM_ROB_ENTS);
   localparam int unsigned CDB_PORTS    = 3;
   localparam int unsigned EX_REQS      = 4;
   localparam int unsigned DATA_W       = 32;

   typedef struct packed {
      logic                 valid;
      logic [ROB_IDX_W-1:0] idx;
      logic [DATA_W-1:0]    val;
   } cdb_pkt_t;

   // (base + off) mod n, used to walk the requesters from the round-robin pointer
   function automatic int unsigned wrap_inc(input int unsigned base,
                                            input int unsigned off,
                                            input int unsigned n);
      return (base + off) % n;
   endfunction

   function automatic int unsigned ptr_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_select.sv
// Rotate-and-pick-first-N selection: walks requesters from the round-robin pointer and
// hands the first NUM_CDB valid ones to CDB ports 0..NUM_CDB-1 in scan order.
module cdb_arbiter_rr_select
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = EX_REQS,
   parameter int unsigned NUM_CDB = CDB_PORTS,
   parameter int unsigned PTR_W   = ptr_w(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [PTR_W-1:0]         i_rr_ptr,
   output logic [NUM_REQ-1:0]       o_grant,
   output logic [NUM_CDB-1:0]       o_port_vld,
   output logic [NUM_CDB*PTR_W-1:0] o_port_sel,
   output logic                     o_any_grant,
   output logic [PTR_W-1:0]         o_next_ptr
);

   // Loops are fully unrolled so every bit/part select uses a constant index
   always_comb begin
      int unsigned cnt;
      int unsigned pos;
      o_grant     = '0;
      o_port_vld  = '0;
      o_port_sel  = '0;
      o_any_grant = 1'b0;
      o_next_ptr  = i_rr_ptr;
      cnt         = 0;
      pos         = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         pos = wrap_inc(32'(i_rr_ptr), k, NUM_REQ);
         for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (pos == r && i_req_valid[r] && cnt < NUM_CDB) begin
               o_grant[r] = 1'b1;
               for (int unsigned c = 0; c < NUM_CDB; c++) begin
                  if (c == cnt) begin
                     o_port_vld[c]                  = 1'b1;
                     o_port_sel[c*PTR_W +: PTR_W]   = PTR_W'(r);
                  end
               end
               cnt         = cnt + 1;
               o_any_grant = 1'b1;
               o_next_ptr  = PTR_W'(wrap_inc(r, 1, NUM_REQ));
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to NUM_CDB execute-unit results per cycle in
// round-robin order and presents them on registered ROB completion ports one cycle later.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = EX_REQS,
   parameter int unsigned NUM_CDB = CDB_PORTS,
   parameter int unsigned IDX_W   = $clog2(NUM_ROB_ENTS)
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*IDX_W-1:0]   req_idx,
   input  logic [NUM_REQ*DATA_W-1:0]  req_val,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       flush,
   output logic [NUM_CDB-1:0]         cdb_valid,
   output logic [NUM_CDB*IDX_W-1:0]   cdb_idx,
   output logic [NUM_CDB*DATA_W-1:0]  cdb_val
);

   localparam int unsigned PTR_W = ptr_w(NUM_REQ);

   logic [NUM_REQ-1:0]       w_grant;
   logic [NUM_CDB-1:0]       w_port_vld;
   logic [NUM_CDB*PTR_W-1:0] w_port_sel;
   logic                     w_any_grant;
   logic [PTR_W-1:0]         w_next_ptr;
   logic                     w_accept;
   logic [PTR_W-1:0]         r_rr_ptr;
   cdb_pkt_t                 w_cdb_nxt [NUM_CDB];
   cdb_pkt_t                 r_cdb     [NUM_CDB];

   cdb_arbiter_rr_select #(
      .NUM_REQ (NUM_REQ),
      .NUM_CDB (NUM_CDB),
      .PTR_W   (PTR_W)
   ) rr_select (
      .i_req_valid (req_valid),
      .i_rr_ptr    (r_rr_ptr),
      .o_grant     (w_grant),
      .o_port_vld  (w_port_vld),
      .o_port_sel  (w_port_sel),
      .o_any_grant (w_any_grant),
      .o_next_ptr  (w_next_ptr)
   );

   // Nothing is accepted during reset or flush, so no transfer can slip through either
   assign w_accept  = rst & ~flush;
   assign req_ready = w_grant & {NUM_REQ{w_accept}};

   // Gather the granted requester's payload onto each port; idle ports stay all-zero
   always_comb begin
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
         w_cdb_nxt[k] = '0;
         if (w_port_vld[k] && w_accept) begin
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
               if (w_port_sel[k*PTR_W +: PTR_W] == PTR_W'(r)) begin
                  w_cdb_nxt[k].valid = 1'b1;
                  w_cdb_nxt[k].idx   = ROB_IDX_W'(req_idx[r*IDX_W +: IDX_W]);
                  w_cdb_nxt[k].val   = req_val[r*DATA_W +: DATA_W];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < NUM_CDB; k++) begin
            r_cdb[k] <= '0;
         end
      end else begin
         for (int unsigned k = 0; k < NUM_CDB; k++) begin
            r_cdb[k] <= w_cdb_nxt[k];
         end
      end
   end

   // Pointer moves past the last granted requester; flush and idle cycles hold it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr_ptr <= '0;
      end else if (w_any_grant && w_accept) begin
         r_rr_ptr <= w_next_ptr;
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < NUM_CDB; k++) begin
         cdb_valid[k]                  = r_cdb[k].valid;
         cdb_idx[k*IDX_W +: IDX_W]     = IDX_W'(r_cdb[k].idx);
         cdb_val[k*DATA_W +: DATA_W]   = r_cdb[k].val;
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed request patterns push hand-derived
// completion-port contents; a negedge monitor pops and compares them when due.
module tb_cdb_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   req_valid;
   logic [19:0]  req_idx;
   logic [127:0] req_val;
   logic [3:0]   req_ready;
   logic         flush;
   logic [2:0]   cdb_valid;
   logic [14:0]  cdb_idx;
   logic [95:0]  cdb_val;

   always #5 clk = ~clk;

   cdb_arbiter #(
      .NUM_REQ (4),
      .NUM_CDB (3),
      .IDX_W   (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_idx   (req_idx),
      .req_val   (req_val),
      .req_ready (req_ready),
      .flush     (flush),
      .cdb_valid (cdb_valid),
      .cdb_idx   (cdb_idx),
      .cdb_val   (cdb_val)
   );

   typedef struct {
      int          due;
      logic [2:0]  vld;
      logic [14:0] idx;
      logic [95:0] val;
      logic [1:0]  ptr;
      string       nm;
   } exp_t;

   exp_t        sb[$];
   int          n_vec  = 0;
   int          n_miss = 0;
   int          cyc    = 0;
   logic [4:0]  tidx [4] = '{5'd5, 5'd9, 5'd17, 5'd30};
   logic [31:0] tval [4] = '{32'h0000_00AA, 32'h1111_2222, 32'hDEAD_BEEF, 32'h0BAD_F00D};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: compare the completion ports against the entry due this cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].due < cyc) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s: expected entry for cycle %0d never compared (now %0d)",
                     sb[0].nm, sb[0].due, cyc);
            void'(sb.pop_front());
         end
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk({e.nm, " cdb_valid"}, 128'(cdb_valid),    128'(e.vld));
            chk({e.nm, " cdb_idx"},   128'(cdb_idx),      128'(e.idx));
            chk({e.nm, " cdb_val"},   128'(cdb_val),      128'(e.val));
            chk({e.nm, " rr_ptr"},    128'(dut.r_rr_ptr), 128'(e.ptr));
         end
      end
   end

   // Requesters must never present the same ROB index at once
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         for (int j = i + 1; j < 4; j++) begin
            if (rst && req_valid[i] && req_valid[j] &&
                req_idx[i*5 +: 5] == req_idx[j*5 +: 5])
               $error("duplicate ROB index on requesters %0d and %0d", i, j);
         end
      end
   end

   // Drive one cycle of requests; n/g0..g2 list the requesters expected on ports 0..n-1
   task automatic step(input logic [3:0] v, input logic f, input logic [3:0] rdy,
                       input int n, input int g0, input int g1, input int g2,
                       input logic [1:0] eptr, input string nm);
      exp_t e;
      int   g [3];
      req_valid = v;
      flush     = f;
      #1;
      chk({nm, " req_ready"}, 128'(req_ready), 128'(rdy));
      g     = '{g0, g1, g2};
      e.due = cyc + 1;
      e.vld = '0;
      e.idx = '0;
      e.val = '0;
      e.ptr = eptr;
      e.nm  = nm;
      for (int k = 0; k < n; k++) begin
         e.vld[k]          = 1'b1;
         e.idx[k*5 +: 5]   = tidx[g[k]];
         e.val[k*32 +: 32] = tval[g[k]];
      end
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         req_idx[i*5 +: 5]   = tidx[i];
         req_val[i*32 +: 32] = tval[i];
      end
      #2 rst = 1'b0;
      #2;
      chk("reset cdb_valid", 128'(cdb_valid),    128'(0));
      chk("reset cdb_idx",   128'(cdb_idx),      128'(0));
      chk("reset cdb_val",   128'(cdb_val),      128'(0));
      chk("reset req_ready", 128'(req_ready),    128'(0));
      chk("reset rr_ptr",    128'(dut.r_rr_ptr), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b1;

      step(4'b0001, 1'b0, 4'b0001, 1, 0, 0, 0, 2'd1, "single_req0");
      step(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 2'd1, "idle_hold");
      step(4'b1000, 1'b0, 4'b1000, 1, 3, 0, 0, 2'd0, "req3_wrap");
      step(4'b1111, 1'b0, 4'b0111, 3, 0, 1, 2, 2'd3, "all_ptr0");
      step(4'b1111, 1'b0, 4'b1011, 3, 3, 0, 1, 2'd2, "all_ptr3");
      step(4'b1111, 1'b0, 4'b1101, 3, 2, 3, 0, 2'd1, "all_ptr2");
      step(4'b1111, 1'b0, 4'b1110, 3, 1, 2, 3, 2'd0, "all_ptr1");
      step(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 2'd0, "flush_all");
      step(4'b0100, 1'b0, 4'b0100, 1, 2, 0, 0, 2'd3, "req2_only");
      step(4'b1010, 1'b0, 4'b1010, 2, 3, 1, 0, 2'd2, "ptr3_1010");
      step(4'b1011, 1'b0, 4'b1011, 3, 3, 0, 1, 2'd2, "three_wrap");
      step(4'b0011, 1'b0, 4'b0011, 2, 0, 1, 0, 2'd2, "two_wrap");
      step(4'b0100, 1'b1, 4'b0000, 0, 0, 0, 0, 2'd2, "flush_one");
      step(4'b0100, 1'b0, 4'b0100, 1, 2, 0, 0, 2'd3, "after_flush");
      step(4'b1111, 1'b0, 4'b1011, 3, 3, 0, 1, 2'd2, "pre_reset");

      // Grant in flight when reset hits mid-cycle must never reach the ports
      req_valid = 4'b1111;
      #1;
      chk("inflight req_ready", 128'(req_ready), 128'(4'b1101));
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("async cdb_valid", 128'(cdb_valid),    128'(0));
      chk("async cdb_idx",   128'(cdb_idx),      128'(0));
      chk("async cdb_val",   128'(cdb_val),      128'(0));
      chk("async rr_ptr",    128'(dut.r_rr_ptr), 128'(0));
      chk("async req_ready", 128'(req_ready),    128'(0));
      @(posedge clk);
      #1;
      chk("discard cdb_valid", 128'(cdb_valid), 128'(0));
      rst = 1'b1;

      step(4'b0110, 1'b0, 4'b0110, 2, 1, 2, 0, 2'd3, "post_reset");
      step(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 2'd3, "drain");
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard drained", 128'(sb.size()), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of execute-unit requesters (ALU0, ALU1, MUL, LSU).
REQ-002 SHALL have parameter NUM_CDB, default 3, meaning the number of ROB completion ports (ExecuteROBIF count).
REQ-003 SHALL have parameter IDX_W, default $clog2(NUM_ROB_ENTS), meaning the ROB index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: result pending per requester.
REQ-007 SHALL have port req_idx, input, NUM_REQ x IDX_W bits: ROB entry index per requester.
REQ-008 SHALL have port req_val, input, NUM_REQ x 32 bits: result value per requester.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: result accepted this cycle.
REQ-010 SHALL have port flush, input, 1 bit: pipeline flush; drops all in-flight completions.
REQ-011 SHALL have port cdb_valid, output, NUM_CDB bits: drives ex_valid of each completion port.
REQ-012 SHALL have port cdb_idx, output, NUM_CDB x IDX_W bits: drives entry_index.
REQ-013 SHALL have port cdb_val, output, NUM_CDB x 32 bits: drives ex_val.

Function
REQ-014 SHALL hold a round-robin pointer rr_ptr (clog2(NUM_REQ) bits) naming the highest-priority requester.
REQ-015 SHALL scan requesters in order rr_ptr, rr_ptr+1, ... mod NUM_REQ and grant the first min(NUM_CDB, number valid) valid ones.
REQ-016 SHALL drive req_ready[i]=1 combinationally iff requester i is granted and flush=0; req_ready SHALL not depend on any other ready.
REQ-017 SHALL treat a transfer as req_valid[i]&req_ready[i]; requesters hold valid, idx, val stable until the transfer.
REQ-018 SHALL route the k-th grant in scan order to CDB port k; unused ports get cdb_valid=0.
REQ-019 SHALL register outputs: a transfer in cycle t appears on cdb_* in cycle t+1 for exactly one cycle (latency 1, no buffering).
REQ-020 SHALL drive cdb_idx and cdb_val to 0 on any port with cdb_valid=0.
REQ-021 SHALL, after a cycle with at least one grant, set rr_ptr to (last granted index + 1) mod NUM_REQ; otherwise rr_ptr holds.
REQ-022 SHALL, when flush=1, grant nothing, clear all cdb_valid the next cycle, and leave rr_ptr unchanged.
REQ-023 SHALL guarantee that any continuously valid requester is granted within ceil(NUM_REQ/NUM_CDB) cycles (no starvation).
REQ-024 SHALL pass duplicate req_idx values unchecked; the bench asserts that no two valid requesters share an index.

Reset
REQ-025 SHALL, while rst=0, asynchronously force cdb_valid=0, cdb_idx=0, cdb_val=0, rr_ptr=0.
REQ-026 SHALL drive req_ready=0 while rst=0; the first grant occurs in the first cycle after rst deasserts.
REQ-027 SHALL discard any completion in flight when reset asserts mid-operation; no output is produced for it.

Structure
REQ-028 SHALL take NUM_ROB_ENTS, NUM_CDB and the CDB payload struct (valid, idx, val) from CORE_PKG.
REQ-029 SHALL place the rotate-and-pick-first-N selection in one combinational sub-module, rr_select.
REQ-030 SHALL contain the only state in rr_ptr and the NUM_CDB output registers.

Verification
REQ-031 SHALL cover: after reset, req_valid=4'b0001, idx=5, val=0xAA -> next cycle cdb_valid=3'b001, cdb_idx[0]=5, cdb_val[0]=0xAA, rr_ptr=1.
REQ-032 SHALL cover: all 4 valid and held for 4 cycles, rr_ptr=0 -> grants {0,1,2}, {3,0,1}, {2,3,0}, {1,2,3}; each requester is served 3 times.
REQ-033 SHALL cover: flush=1 with req_valid=4'b1111 -> req_ready=0, next-cycle cdb_valid=0, rr_ptr unchanged.
REQ-034 SHALL cover: rst asserted asynchronously mid-cycle while cdb_valid=3'b111 -> outputs 0 immediately, before any clock edge.
REQ-035 SHALL cover: rr_ptr=3, req_valid=4'b1010 -> grants requesters 3 then 1 on ports 0 and 1, next rr_ptr=2.
